// File: rtl/usb_host_txn_ctrl.sv
// Host-side USB transaction sequencer.
// Builds token / DATA0 / ACK packet images for the encoder and launches them
// one at a time. It then waits for the device's handshake or data packet and
// retries on NAK, timeout or bad CRC until the retry budget is spent.
module usb_host_txn_ctrl #(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dir,
  input  logic [6:0]  req_addr,
  input  logic [3:0]  req_endp,
  input  logic [63:0] req_data,
  output logic        done,
  output logic [1:0]  status,
  output logic [63:0] rd_data,
  output logic [2:0]  retry_cnt,
  output logic [98:0] pkt_out,
  output logic        pkt_avail,
  input  logic        enc_busy,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_crc_ok
);

  localparam logic [3:0] PID_OUT   = 4'b1000;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b1100;
  localparam logic [3:0] PID_ACK   = 4'b0100;
  localparam logic [3:0] PID_NAK   = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO, S_HS_WAIT, S_RX_WAIT, S_DONE
  } state_t;

  // Names the packet currently on the wire, and so where WAIT_LO goes next
  typedef enum logic [1:0] {RET_TOKEN, RET_DATA, RET_ACK} ret_t;

  state_t      state;
  ret_t        ret_sel;
  logic        dir;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;
  logic [7:0]  tcnt;

  logic expired, fail, fail_nak, rx_good;

  // Sync + PID + inverted PID; the encoder fills in CRC bits later
  function automatic logic [98:0] pkt_hdr(input logic [3:0] pid);
    logic [98:0] p;
    p         = '0;
    p[98:91]  = 8'b0000_0001;
    p[90:87]  = pid;
    p[86:83]  = ~pid;
    return p;
  endfunction

  // Address and endpoint go out LSB first, so bit 0 lands at the top field bit
  function automatic logic [98:0] token_pkt(input logic is_in,
                                            input logic [6:0] a,
                                            input logic [3:0] e);
    logic [98:0] p;
    p = pkt_hdr(is_in ? PID_IN : PID_OUT);
    for (int i = 0; i < 7; i++) p[82-i] = a[i];
    for (int i = 0; i < 4; i++) p[75-i] = e[i];
    return p;
  endfunction

  function automatic logic [98:0] data_pkt(input logic [63:0] d);
    logic [98:0] p;
    p = pkt_hdr(PID_DATA0);
    for (int i = 0; i < 64; i++) p[82-i] = d[i];
    return p;
  endfunction

  // Classify this cycle's outcome in the waiting states; a response beats expiry
  always_comb begin
    expired  = (tcnt == 8'(TIMEOUT));
    fail     = 1'b0;
    fail_nak = 1'b0;
    rx_good  = 1'b0;
    case (state)
      S_WAIT_HI: fail = !enc_busy && expired;
      S_HS_WAIT: begin
        if (rx_valid) begin
          rx_good  = (rx_pid == PID_ACK);
          fail     = !rx_good;
          fail_nak = (rx_pid == PID_NAK);
        end else begin
          fail = expired;
        end
      end
      S_RX_WAIT: begin
        if (rx_valid) begin
          rx_good  = (rx_pid == PID_DATA0) && rx_crc_ok;
          fail     = !rx_good;
          fail_nak = (rx_pid == PID_NAK);
        end else begin
          fail = expired;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered outputs; retry handling overrides the per-state step
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      ret_sel   <= RET_TOKEN;
      req_ready <= 1'b1;
      done      <= 1'b0;
      status    <= 2'b00;
      rd_data   <= '0;
      retry_cnt <= '0;
      pkt_out   <= '0;
      pkt_avail <= 1'b0;
      tcnt      <= '0;
      dir       <= 1'b0;
      addr      <= '0;
      endp      <= '0;
      data      <= '0;
    end else begin
      pkt_avail <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            dir       <= req_dir;
            addr      <= req_addr;
            endp      <= req_endp;
            data      <= req_data;
            retry_cnt <= '0;
            pkt_out   <= token_pkt(req_dir, req_addr, req_endp);
            ret_sel   <= RET_TOKEN;
            pkt_avail <= 1'b1;
            req_ready <= 1'b0;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (enc_busy)   state <= S_WAIT_LO;
          else if (!fail) tcnt  <= tcnt + 8'd1;
        end
        S_WAIT_LO: begin
          if (!enc_busy) begin
            case (ret_sel)
              RET_TOKEN: begin
                if (dir) begin
                  tcnt  <= '0;
                  state <= S_RX_WAIT;
                end else begin
                  pkt_out   <= data_pkt(data);
                  ret_sel   <= RET_DATA;
                  pkt_avail <= 1'b1;
                  state     <= S_LAUNCH;
                end
              end
              RET_DATA: begin
                tcnt  <= '0;
                state <= S_HS_WAIT;
              end
              default: begin
                status <= 2'b00;
                done   <= 1'b1;
                state  <= S_DONE;
              end
            endcase
          end
        end
        S_HS_WAIT: begin
          if (rx_valid && rx_good) begin
            status <= 2'b00;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (!fail) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_RX_WAIT: begin
          if (rx_valid && rx_good) begin
            rd_data   <= rx_data;
            pkt_out   <= pkt_hdr(PID_ACK);
            ret_sel   <= RET_ACK;
            pkt_avail <= 1'b1;
            state     <= S_LAUNCH;
          end else if (!fail) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_DONE: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (fail) begin
        if (retry_cnt < 3'(MAX_RETRY)) begin
          retry_cnt <= retry_cnt + 3'd1;
          pkt_out   <= token_pkt(dir, addr, endp);
          ret_sel   <= RET_TOKEN;
          pkt_avail <= 1'b1;
          state     <= S_LAUNCH;
        end else begin
          status <= fail_nak ? 2'b01 : 2'b10;
          done   <= 1'b1;
          state  <= S_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_host_txn_ctrl.sv
// Scoreboard bench for usb_host_txn_ctrl: an encoder/device model drives the
// DUT, a transaction-level model predicts packets and completions, and a
// monitor compares them as the DUT presents them.
module tb_usb_host_txn_ctrl;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 255;
  localparam int R_ACK = 0, R_NAK = 1, R_NONE = 2, R_BAD = 3, R_DOK = 4, R_DBAD = 5, R_LATE = 6;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid, req_ready, req_dir;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [63:0] req_data;
  logic        done;
  logic [1:0]  status;
  logic [63:0] rd_data;
  logic [2:0]  retry_cnt;
  logic [98:0] pkt_out;
  logic        pkt_avail;
  logic        enc_busy, rx_valid, rx_crc_ok;
  logic [3:0]  rx_pid;
  logic [63:0] rx_data;

  usb_host_txn_ctrl #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
    .done(done), .status(status), .rd_data(rd_data), .retry_cnt(retry_cnt),
    .pkt_out(pkt_out), .pkt_avail(pkt_avail), .enc_busy(enc_busy),
    .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_crc_ok(rx_crc_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [63:0] rd;
    logic [2:0]  rt;
    bit          chk_rd;
  } exp_t;

  exp_t        exp_done_q[$];
  logic [98:0] exp_pkt_q[$];
  int          resp_q[$];
  int          errors = 0, checks = 0, cyc = 0, done_cnt = 0;
  int          enc_lo = 3, enc_hi = 12, gap_ref = 0;
  bit          gap_armed = 0, tok_const = 0, ack_const = 0, skip_stable = 0;
  logic [63:0] in_data = '0;
  logic [3:0]  busy_pid = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [98:0] act, input logic [98:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference packet images straight from the field layout, using streaming reversal
  function automatic logic [98:0] tok_img(input logic is_in, input logic [6:0] a, input logic [3:0] e);
    logic [3:0] pid;
    logic [6:0] ar;
    logic [3:0] er;
    pid = is_in ? 4'b1001 : 4'b1000;
    ar  = {<<{a}};
    er  = {<<{e}};
    return {8'h01, pid, ~pid, ar, er, 72'b0};
  endfunction

  function automatic logic [98:0] dat_img(input logic [63:0] d);
    logic [63:0] dr;
    dr = {<<{d}};
    return {8'h01, 4'b1100, 4'b0011, dr, 19'b0};
  endfunction

  function automatic logic [98:0] ack_img();
    return {8'h01, 4'b0100, 4'b1011, 83'b0};
  endfunction

  // Transaction-level prediction: walk attempts against the device script
  task automatic model_txn(input logic dir, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d, input logic [63:0] din, input int scr[4]);
    exp_t x;
    bit   ok;
    int   st;
    ok = 0; st = 2; x.rt = 3'(MAX_RETRY);
    for (int at = 0; at <= MAX_RETRY; at++) begin
      exp_pkt_q.push_back(tok_img(dir, a, e));
      if (!dir) exp_pkt_q.push_back(dat_img(d));
      if (!dir && (scr[at] == R_ACK || scr[at] == R_LATE)) begin ok = 1; x.rt = 3'(at); break; end
      if (dir && scr[at] == R_DOK) begin exp_pkt_q.push_back(ack_img()); ok = 1; x.rt = 3'(at); break; end
      st = (scr[at] == R_NAK) ? 1 : 2;
    end
    x.st     = ok ? 2'b00 : 2'(st);
    x.rd     = din;
    x.chk_rd = ok && dir;
    exp_done_q.push_back(x);
  endtask

  // Encoder busy model plus device responder
  initial begin
    logic [98:0] launched;
    int          r, dly, elen;
    bit          stable_ok;
    enc_busy = 0; rx_valid = 0; rx_pid = '0; rx_data = '0; rx_crc_ok = 0;
    forever begin
      @(negedge clk);
      if (rst_b && pkt_avail) begin
        launched  = pkt_out;
        busy_pid  = pkt_out[90:87];
        stable_ok = 1;
        elen      = $urandom_range(enc_hi, enc_lo);
        @(posedge clk); #1 enc_busy = 1;
        for (int k = 0; k < elen; k++) begin
          @(negedge clk);
          if (!skip_stable && pkt_out !== launched) stable_ok = 0;
          @(posedge clk);
        end
        #1 enc_busy = 0;
        if (!skip_stable) chk("pkt_stable", 99'(stable_ok), 99'(1));
        if (launched[90:87] == 4'b1100 || launched[90:87] == 4'b1001) begin
          r = (resp_q.size() > 0) ? resp_q.pop_front() : R_NONE;
          if (r == R_NONE) begin
            gap_armed = 1; gap_ref = cyc;
          end else begin
            dly = (r == R_LATE) ? TIMEOUT + 1 : $urandom_range(20, 1);
            repeat (dly) @(posedge clk);
            #1 rx_valid = 1; rx_crc_ok = 1; rx_data = {$urandom, $urandom};
            case (r)
              R_ACK, R_LATE: rx_pid = 4'b0100;
              R_NAK:         rx_pid = 4'b0101;
              R_DOK:         begin rx_pid = 4'b1100; rx_data = in_data; end
              R_DBAD:        begin rx_pid = 4'b1100; rx_crc_ok = 0; rx_data = ~in_data; end
              default:       rx_pid = 4'b1110;
            endcase
            @(posedge clk); #1 rx_valid = 0;
          end
        end
      end
    end
  end

  // Monitor: compare launched packets and completions against the scoreboard
  always @(negedge clk) begin
    if (rst_b) begin
      if (gap_armed && (pkt_avail || done)) begin
        chk("timeout_gap", 99'(cyc - gap_ref), 99'(TIMEOUT + 2));
        gap_armed = 0;
      end
      if (pkt_avail) begin
        if (exp_pkt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt: got %h, want no launch", pkt_out);
        end else begin
          chk("pkt_image", pkt_out, exp_pkt_q.pop_front());
        end
        if (tok_const) begin
          chk("token_fields", 99'(pkt_out[90:72]), 99'(19'b1000_0111_1010000_0100));
          tok_const = 0;
        end
        if (ack_const && pkt_out[90:87] == 4'b0100) begin
          chk("ack_fields", 99'(pkt_out[90:83]), 99'(8'b0100_1011));
          ack_const = 0;
        end
      end
      if (done) begin
        exp_t x;
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got status %b, want no done", status);
        end else begin
          x = exp_done_q.pop_front();
          chk("status", 99'(status), 99'(x.st));
          chk("retry_cnt", 99'(retry_cnt), 99'(x.rt));
          if (x.chk_rd) chk("rd_data", 99'(rd_data), 99'(x.rd));
        end
      end
    end
  end

  task automatic issue(input logic dir, input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 2000) begin @(negedge clk); w++; end
    if (!req_ready) begin checks++; errors++; $display("FAIL req_ready_wait: got 0, want 1"); end
    req_valid = 1; req_dir = dir; req_addr = a; req_endp = e; req_data = d;
    @(posedge clk);
    // keep a bogus request asserted while busy: it must be ignored
    #1 req_dir = ~dir; req_addr = ~a; req_endp = ~e; req_data = ~d;
    @(negedge clk);
    chk("launch_latency", 99'(pkt_avail), 99'(1));
    repeat (2) @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic run_txn(input logic dir, input logic [6:0] a, input logic [3:0] e,
                         input logic [63:0] d, input logic [63:0] din,
                         input int s0, input int s1, input int s2, input int s3);
    int scr[4];
    int w;
    scr = '{s0, s1, s2, s3};
    resp_q.delete();
    foreach (scr[k]) resp_q.push_back(scr[k]);
    in_data = din;
    model_txn(dir, a, e, d, din, scr);
    issue(dir, a, e, d);
    w = 0;
    while (exp_done_q.size() != 0 && w < 6000) begin @(negedge clk); w++; end
    if (exp_done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done after %0d cycles, want done", w);
      exp_done_q.delete(); exp_pkt_q.delete();
    end
    @(negedge clk);
    chk("idle_ready", 99'(req_ready), 99'(1));
    chk("done_one_cycle", 99'(done), 99'(0));
    chk("pkts_left", 99'(exp_pkt_q.size()), 99'(0));
    resp_q.delete();
  endtask

  task automatic random_txn();
    logic rdir;
    int   s[4];
    int   p;
    rdir = 1'($urandom_range(1, 0));
    for (int k = 0; k < 4; k++) begin
      p = $urandom_range(7, 0);
      if (rdir) s[k] = (p < 3) ? R_DOK : (p == 3) ? R_DBAD : (p == 4) ? R_NAK : (p == 5) ? R_BAD : (p == 6) ? R_DOK : R_NONE;
      else      s[k] = (p < 3) ? R_ACK : (p < 5) ? R_NAK : (p == 5) ? R_BAD : (p == 6) ? R_ACK : R_NONE;
    end
    run_txn(rdir, 7'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            s[0], s[1], s[2], s[3]);
  endtask

  task automatic reset_mid_data0();
    int w, d0;
    resp_q.delete(); resp_q.push_back(R_NONE);
    exp_pkt_q.push_back(tok_img(1'b0, 7'h11, 4'h3));
    exp_pkt_q.push_back(dat_img(64'hDEAD_BEEF_0000_1111));
    enc_lo = 20; enc_hi = 20;
    d0 = done_cnt;
    issue(1'b0, 7'h11, 4'h3, 64'hDEAD_BEEF_0000_1111);
    w = 0;
    while (!(enc_busy && busy_pid == 4'b1100) && w < 500) begin @(negedge clk); w++; end
    chk("data0_busy_seen", 99'(enc_busy && busy_pid == 4'b1100), 99'(1));
    repeat (2) @(negedge clk);
    skip_stable = 1;
    rst_b = 0;
    @(negedge clk);
    chk("rst_req_ready", 99'(req_ready), 99'(1));
    chk("rst_pkt_avail", 99'(pkt_avail), 99'(0));
    chk("rst_retry_cnt", 99'(retry_cnt), 99'(0));
    rst_b = 1;
    w = 0;
    while (enc_busy && w < 500) begin @(negedge clk); w++; end
    repeat (20) @(negedge clk);
    gap_armed = 0; skip_stable = 0;
    chk("rst_no_done", 99'(done_cnt), 99'(d0));
    chk("rst_pkts_left", 99'(exp_pkt_q.size()), 99'(0));
    resp_q.delete();
  endtask

  initial begin
    rst_b = 0; req_valid = 0; req_dir = 0; req_addr = '0; req_endp = '0; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 99'(req_ready), 99'(1));
    chk("reset_done", 99'(done), 99'(0));
    chk("reset_status", 99'(status), 99'(0));
    chk("reset_rd_data", 99'(rd_data), 99'(0));
    chk("reset_retry_cnt", 99'(retry_cnt), 99'(0));
    chk("reset_pkt_out", pkt_out, 99'(0));
    chk("reset_pkt_avail", 99'(pkt_avail), 99'(0));
    rst_b = 1;
    repeat (2) @(negedge clk);

    // OUT success with the reference fields
    enc_lo = 35; enc_hi = 99; tok_const = 1;
    run_txn(1'b0, 7'h05, 4'h2, 64'h0123_4567_89AB_CDEF, '0, R_ACK, R_ACK, R_ACK, R_ACK);
    enc_lo = 3; enc_hi = 12;
    // OUT, device always NAKs
    run_txn(1'b0, 7'h33, 4'h9, 64'h1111_2222_3333_4444, '0, R_NAK, R_NAK, R_NAK, R_NAK);
    // IN success
    ack_const = 1;
    run_txn(1'b1, 7'h7F, 4'hF, '0, 64'hA5A5_0000_FFFF_1234, R_DOK, R_DOK, R_DOK, R_DOK);
    // IN bad CRC, then success
    run_txn(1'b1, 7'h01, 4'h8, '0, 64'h0F0F_1234_5678_9ABC, R_DBAD, R_DOK, R_DOK, R_DOK);
    // OUT, no response at all
    run_txn(1'b0, 7'h2A, 4'h5, 64'hCAFE_F00D_0000_0001, '0, R_NONE, R_NONE, R_NONE, R_NONE);
    // OUT, ACK on the exact expiry cycle
    run_txn(1'b0, 7'h44, 4'h1, 64'h8000_0000_0000_0001, '0, R_LATE, R_NONE, R_NONE, R_NONE);
    // IN, mixed errors ending in error status
    run_txn(1'b1, 7'h12, 4'h6, '0, 64'h1, R_BAD, R_NAK, R_NONE, R_DBAD);
    // reset while DATA0 is on the wire
    reset_mid_data0();
    enc_lo = 3; enc_hi = 12;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 12; t++) random_txn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end
endmodule
